// File: rtl/const_mon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | const_mon_pkg                                                            |
// | Shared types and constants for the constant tie-off level monitor.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package const_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ARMED  = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam int FC_ONE_LOW   = 0;
  localparam int FC_ZERO_HIGH = 1;
  localparam int SETTLE_LEN   = 2;

endpackage
`default_nettype wire

// File: rtl/const_mon_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | const_mon_sync2                                                          |
// | Two-flop synchronizer whose reset value matches the expected level.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module const_mon_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/const_level_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | const_level_monitor                                                      |
// | Debounced checker of the one/zero tie nets with sticky fault and clear. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module const_level_monitor
  import const_mon_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             one_i,
  input  logic             zero_i,
  input  logic             enable,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic             armed,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0] c_debounce    = 8'(DEBOUNCE);
  localparam logic [1:0] c_settle_last = 2'(SETTLE_LEN - 1);

  logic             w_one_s;
  logic             w_zero_s;
  logic [1:0]       w_mis;
  logic             w_clr_evt;

  state_e           r_state, w_state_nxt;
  logic [7:0]       r_db_cnt, w_db_nxt, w_db_inc;
  logic [1:0]       r_settle, w_settle_nxt;
  logic             r_fault, w_fault_nxt;
  logic [1:0]       r_code, w_code_nxt;
  logic [CNT_W-1:0] r_err_cnt, w_err_nxt, w_err_inc;
  logic             r_clr_ack;

  const_mon_sync2 #(.RESET_VAL(1'b1)) u_sync_one (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .i_d (one_i),
    .o_q (w_one_s)
  );

  const_mon_sync2 #(.RESET_VAL(1'b0)) u_sync_zero (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .i_d (zero_i),
    .o_q (w_zero_s)
  );

  always_comb begin
    w_mis               = '0;
    w_mis[FC_ONE_LOW]   = ~w_one_s;
    w_mis[FC_ZERO_HIGH] = w_zero_s;
  end

  assign w_clr_evt = clr_req & ~r_clr_ack;
  assign w_db_inc  = r_db_cnt + 8'd1;
  assign w_err_inc = (&r_err_cnt) ? r_err_cnt : r_err_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_db_nxt     = r_db_cnt;
    w_settle_nxt = r_settle;
    w_fault_nxt  = r_fault;
    w_code_nxt   = r_code;
    w_err_nxt    = r_err_cnt;

    if (!enable) begin
      w_state_nxt = IDLE;
      w_db_nxt    = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt  = SETTLE;
          w_settle_nxt = '0;
        end
        SETTLE: begin
          if (r_settle == c_settle_last) w_state_nxt = ARMED;
          else                           w_settle_nxt = r_settle + 2'd1;
        end
        ARMED: begin
          if (w_mis != 2'b00) begin
            if (w_db_inc == c_debounce) begin
              w_state_nxt = FAULT;
              w_db_nxt    = '0;
              w_fault_nxt = 1'b1;
              w_code_nxt  = r_code | w_mis;
              w_err_nxt   = w_err_inc;
            end else begin
              w_db_nxt = w_db_inc;
            end
          end else begin
            w_db_nxt = '0;
          end
        end
        FAULT:   w_code_nxt = r_code | w_mis;
        default: w_state_nxt = IDLE;
      endcase
    end

    // A clear beats a debounce completing on the same edge.
    if (w_clr_evt) begin
      w_fault_nxt = 1'b0;
      w_code_nxt  = '0;
      w_err_nxt   = '0;
      w_db_nxt    = '0;
      if (enable && (r_state == ARMED || r_state == FAULT)) w_state_nxt = ARMED;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_db_cnt  <= '0;
      r_settle  <= '0;
      r_fault   <= 1'b0;
      r_code    <= '0;
      r_err_cnt <= '0;
      r_clr_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_db_cnt  <= w_db_nxt;
      r_settle  <= w_settle_nxt;
      r_fault   <= w_fault_nxt;
      r_code    <= w_code_nxt;
      r_err_cnt <= w_err_nxt;
      r_clr_ack <= clr_req;
    end
  end

  assign clr_ack    = r_clr_ack;
  assign armed      = (r_state == ARMED);
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign err_count  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_const_level_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_const_level_monitor                                                   |
// | Self-checking bench with a behavioural model of the level monitor.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_const_level_monitor;

  localparam int DEBOUNCE = 4;
  localparam int CNT_W    = 2;
  localparam int ERR_MAX  = (1 << CNT_W) - 1;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic             one_i, zero_i, enable, clr_req;
  logic             clr_ack, armed, fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] err_count;

  const_level_monitor #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .one_i      (one_i),
    .zero_i     (zero_i),
    .enable     (enable),
    .clr_req    (clr_req),
    .clr_ack    (clr_ack),
    .armed      (armed),
    .fault      (fault),
    .fault_code (fault_code),
    .err_count  (err_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_pass  = 0;
  int n_total = 0;

  // Model: phase 0 idle, 1 settling, 2 watching, 3 faulted.
  int       md_phase, md_settle, md_run, md_err;
  bit       md_o1, md_o2, md_z1, md_z2, md_ack, md_fault;
  bit [1:0] md_code;

  logic [4+CNT_W:0] obs;
  assign obs = {clr_ack, armed, fault, fault_code, err_count};

  function automatic logic [4+CNT_W:0] expv();
    return {md_ack, (md_phase == 2), md_fault, md_code, CNT_W'(md_err)};
  endfunction

  task automatic model_reset();
    md_phase = 0; md_settle = 0; md_run = 0; md_err = 0;
    md_o1 = 1; md_o2 = 1; md_z1 = 0; md_z2 = 0;
    md_ack = 0; md_fault = 0; md_code = 2'b00;
  endtask

  task automatic model_edge();
    bit [1:0] mm;
    bit       clr;
    mm  = {md_z2, ~md_o2};
    clr = clr_req && !md_ack;
    md_o2 = md_o1; md_o1 = one_i;
    md_z2 = md_z1; md_z1 = zero_i;
    md_ack = clr_req;
    if (!enable) begin
      md_phase = 0; md_run = 0;
    end else if (md_phase == 0) begin
      md_phase = 1; md_settle = 0;
    end else if (md_phase == 1) begin
      md_settle++;
      if (md_settle == 2) md_phase = 2;
    end else if (md_phase == 2) begin
      md_run = (mm != 0) ? md_run + 1 : 0;
      if (md_run == DEBOUNCE) begin
        md_phase = 3; md_fault = 1; md_code |= mm; md_run = 0;
        if (md_err < ERR_MAX) md_err++;
      end
    end else begin
      md_code |= mm;
    end
    if (clr) begin
      md_fault = 0; md_code = 0; md_err = 0; md_run = 0;
      if (enable && md_phase == 3) md_phase = 2;
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    model_edge();
    @(negedge wb_clk_i);
  endtask

  task automatic test_reset();
    wb_rst_i = 1; one_i = 1; zero_i = 0; enable = 0; clr_req = 0;
    #12;
    model_reset();
    n_total++;
    if (obs !== '0) $display("FAIL reset_values: got %b expected %b", obs, {(5+CNT_W){1'b0}});
    else n_pass++;
    @(negedge wb_clk_i);
    wb_rst_i = 0;
  endtask

  task automatic test_enable_clean();
    enable = 1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      n_total++;
      if (obs !== expv()) $display("FAIL clean_run c=%0d: got %b expected %b", c, obs, expv());
      else n_pass++;
      if (c == 2 || c == 3) begin
        n_total++;
        if (armed !== (c == 3)) $display("FAIL armed_timing c=%0d: got %b expected %b", c, armed, (c == 3));
        else n_pass++;
      end
    end
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 12; c++) begin
      one_i = (c < 3) ? 1'b0 : 1'b1;
      tick();
      n_total++;
      if (obs !== expv()) $display("FAIL glitch c=%0d: got %b expected %b", c, obs, expv());
      else n_pass++;
    end
    n_total++;
    if ({fault, err_count} !== '0) $display("FAIL glitch_no_fault: got %b expected 0", {fault, err_count});
    else n_pass++;
  endtask

  task automatic test_fault_latency();
    one_i = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_total++;
      if (fault !== (k >= 6)) $display("FAIL fault_latency k=%0d: got %b expected %b", k, fault, (k >= 6));
      else n_pass++;
      n_total++;
      if (obs !== expv()) $display("FAIL fault_model k=%0d: got %b expected %b", k, obs, expv());
      else n_pass++;
    end
    n_total++;
    if ({fault_code, err_count} !== {2'b01, 2'd1})
      $display("FAIL fault_cause: got %b expected %b", {fault_code, err_count}, {2'b01, 2'd1});
    else n_pass++;
  endtask

  task automatic test_fault_code_or();
    zero_i = 1;
    tick();
    zero_i = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++;
      if (obs !== expv()) $display("FAIL code_or k=%0d: got %b expected %b", k, obs, expv());
      else n_pass++;
    end
    n_total++;
    if ({fault_code, err_count} !== {2'b11, 2'd1})
      $display("FAIL code_or_final: got %b expected %b", {fault_code, err_count}, {2'b11, 2'd1});
    else n_pass++;
  endtask

  task automatic test_clear();
    one_i = 1;
    repeat (3) tick();
    clr_req = 1;
    tick();
    n_total++;
    if ({clr_ack, armed, fault, err_count} !== {3'b110, 2'd0})
      $display("FAIL clear_first: got %b expected %b", {clr_ack, armed, fault, err_count}, {3'b110, 2'd0});
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if (obs !== expv()) $display("FAIL clear_hold k=%0d: got %b expected %b", k, obs, expv());
      else n_pass++;
    end
    clr_req = 0;
    tick();
    n_total++;
    if (clr_ack !== 1'b0) $display("FAIL clear_ack_fall: got %b expected 0", clr_ack);
    else n_pass++;
  endtask

  task automatic test_coincident_clear();
    one_i = 0;
    for (int k = 1; k <= 11; k++) begin
      clr_req = (k >= 6);
      tick();
      n_total++;
      if (obs !== expv()) $display("FAIL coincide k=%0d: got %b expected %b", k, obs, expv());
      else n_pass++;
      if (k == 6 || k == 9 || k == 10) begin
        n_total++;
        if (fault !== (k == 10)) $display("FAIL coincide_fault k=%0d: got %b expected %b", k, fault, (k == 10));
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      clr_req = 0;
      tick();
      clr_req = 1;
      for (int j = 0; j <= DEBOUNCE; j++) begin
        tick();
        n_total++;
        if (fault !== (j == DEBOUNCE)) $display("FAIL refault r=%0d j=%0d: got %b expected %b", r, j, fault, (j == DEBOUNCE));
        else n_pass++;
        n_total++;
        if (obs !== expv()) $display("FAIL refault_model r=%0d j=%0d: got %b expected %b", r, j, obs, expv());
        else n_pass++;
      end
    end
    clr_req = 0;
    for (int i = 0; i < 4; i++) begin
      enable = 0;
      tick();
      n_total++;
      if ({armed, fault} !== 2'b01) $display("FAIL drop_enable i=%0d: got %b expected 01", i, {armed, fault});
      else n_pass++;
      enable = 1;
      repeat (7) tick();
      n_total++;
      if ({fault, err_count} !== {1'b1, CNT_W'((i + 2 > ERR_MAX) ? ERR_MAX : i + 2)})
        $display("FAIL saturate i=%0d: got %b expected %b", i, {fault, err_count},
                 {1'b1, CNT_W'((i + 2 > ERR_MAX) ? ERR_MAX : i + 2)});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    #2 wb_rst_i = 1;
    #1;
    model_reset();
    n_total++;
    if (obs !== '0) $display("FAIL reset_in_fault: got %b expected 0", obs);
    else n_pass++;
    @(negedge wb_clk_i);
    wb_rst_i = 0; one_i = 1; zero_i = 0; enable = 1;
    repeat (3) tick();
    zero_i = 1;
    repeat (4) tick();
    n_total++;
    if (obs !== expv()) $display("FAIL pre_reset_debounce: got %b expected %b", obs, expv());
    else n_pass++;
    #2 wb_rst_i = 1;
    #1;
    model_reset();
    n_total++;
    if (obs !== '0) $display("FAIL reset_mid_debounce: got %b expected 0", obs);
    else n_pass++;
    @(negedge wb_clk_i);
    wb_rst_i = 0; zero_i = 0;
  endtask

  task automatic test_random();
    int bad_len = 0;
    int bad_net = 0;
    for (int c = 0; c < 800; c++) begin
      enable = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 9) == 0) clr_req = ~clr_req;
      if (bad_len == 0 && $urandom_range(0, 9) == 0) begin
        bad_len = $urandom_range(1, 9);
        bad_net = $urandom_range(0, 2);
      end
      one_i  = !(bad_len > 0 && bad_net != 1);
      zero_i =  (bad_len > 0 && bad_net != 0);
      if (bad_len > 0) bad_len--;
      tick();
      n_total++;
      if (obs !== expv()) $display("FAIL random c=%0d: got %b expected %b", c, obs, expv());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_enable_clean();
    test_glitch();
    test_fault_latency();
    test_fault_code_or();
    test_clear();
    test_coincident_clear();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
